coef_bank_server: RTL

//  Responder side of the filter coefficient-fetch interface: answers coefaddress with coefdata.

---
 rtl/coef_pkg.sv | 14 +
 rtl/coef_bank.sv | 23 ++
 rtl/coef_bank_server.sv | 109 ++++++++++
 3 files changed

// File: rtl/coef_pkg.sv
// Shared constants and load-FSM encoding for the coefficient server
// and the filter that fetches from it.
package coef_pkg;
    localparam int NTAPS   = 65;
    localparam int COEF_W  = 18;
    localparam int ADDR_W  = 7;
    localparam int LDSUM_W = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } ld_state_t;
endpackage

// File: rtl/coef_bank.sv
// One bank of NTAPS coefficients: synchronous write port and
// registered read port. Out-of-range addresses are never applied.
module coef_bank
    import coef_pkg::*;
(
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [COEF_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [COEF_W-1:0] rdata
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NTAPS - 1);

    logic [COEF_W-1:0] mem [NTAPS];

    always_ff @(posedge clock) begin
        if (we && waddr <= LAST)
            mem[waddr] <= wdata;
        if (raddr <= LAST)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/coef_bank_server.sv
// Double-buffered coefficient store: host loads the shadow bank,
// which becomes active only on a filter frame boundary.
module coef_bank_server
    import coef_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  coefaddress,
    output logic [COEF_W-1:0]  coefdata,
    input  logic               frame_sync,
    input  logic               ld_start,
    input  logic               ld_valid,
    input  logic [COEF_W-1:0]  ld_data,
    output logic               ld_ready,
    output logic               bank_sel,
    output logic               swap_done,
    output logic [LDSUM_W-1:0] ld_sum
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NTAPS - 1);

    ld_state_t         state, state_n;
    logic [ADDR_W-1:0] wptr;
    logic [1:0]        vld;
    logic              rsel, rok;
    logic              accept, last, swap;
    logic [COEF_W-1:0] rd0, rd1;

    always_comb begin
        state_n  = state;
        ld_ready = 1'b0;
        accept   = 1'b0;
        last     = 1'b0;
        swap     = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) state_n = LOAD;
            end
            LOAD: begin
                ld_ready = 1'b1;
                // a word arriving with ld_start belongs to the aborted load
                accept   = ld_valid && !ld_start;
                last     = accept && (wptr == LAST);
                if (last) state_n = PENDING;
            end
            PENDING: begin
                if (ld_start) begin
                    state_n = LOAD;
                end else if (frame_sync) begin
                    swap    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wptr      <= '0;
            bank_sel  <= 1'b0;
            vld       <= '0;
            ld_sum    <= '0;
            swap_done <= 1'b0;
            rsel      <= 1'b0;
            rok       <= 1'b0;
        end else begin
            state     <= state_n;
            swap_done <= swap;
            // qualify the read with the bank state seen by this address
            rsel      <= bank_sel;
            rok       <= (coefaddress <= LAST) && vld[bank_sel];
            if (ld_start) begin
                wptr          <= '0;
                ld_sum        <= '0;
                vld[~bank_sel] <= 1'b0;
            end else if (accept) begin
                wptr   <= wptr + 1'b1;
                ld_sum <= ld_sum
                        + {{(LDSUM_W-COEF_W){ld_data[COEF_W-1]}}, ld_data};
                if (last) vld[~bank_sel] <= 1'b1;
            end
            if (swap) begin
                bank_sel      <= ~bank_sel;
                vld[bank_sel] <= 1'b0;
            end
        end
    end

    coef_bank u_bank0 (
        .clock (clock),
        .we    (accept && bank_sel),
        .waddr (wptr),
        .wdata (ld_data),
        .raddr (coefaddress),
        .rdata (rd0)
    );

    coef_bank u_bank1 (
        .clock (clock),
        .we    (accept && !bank_sel),
        .waddr (wptr),
        .wdata (ld_data),
        .raddr (coefaddress),
        .rdata (rd1)
    );

    assign coefdata = rok ? (rsel ? rd1 : rd0) : '0;
endmodule
